mul5b_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `mul5bj` 5×5 unsigned array multiplier among `NREQ` requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester at a time, registers its operands, and captures the 10-bit product. It then returns the product, tagged with the requester index, on a single valid/ready output port. It sits between the operand producers and the result consumer, so the team instantiates one multiplier instead of `NREQ`.

---
 rtl/mul5b_pkg.sv | 13 +
 rtl/mul5b_arb_if.sv | 28 ++
 rtl/mul5b_arb_rr_pick.sv | 30 +++
 rtl/mul5bj.sv | 19 +
 rtl/mul5b_arb.sv | 115 +++++++++++
 tb/tb_mul5b_arb.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/mul5b_pkg.sv
// Shared constants and FSM state encoding for the mul5b_arb multiplier-sharing block.
package mul5b_pkg;

    localparam int unsigned OPW = 5;
    localparam int unsigned PW  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul5b_arb_if.sv
// Requester-side and result-side handshake bundle for mul5b_arb.
interface mul5b_arb_if
    import mul5b_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*OPW-1:0]  req_x;
    logic [NREQ*OPW-1:0]  req_y;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [PW-1:0]        out_z;
    logic [IDW-1:0]       out_id;

    modport master (
        output req_valid, req_x, req_y, out_ready,
        input  req_ready, out_valid, out_z, out_id
    );

    modport slave (
        input  req_valid, req_x, req_y, out_ready,
        output req_ready, out_valid, out_z, out_id
    );

endinterface

// File: rtl/mul5b_arb_rr_pick.sv
// Round-robin one-hot picker: first set request at or above ptr, wrapping at NREQ-1.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gidx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mul5bj.sv
// 5x5 unsigned array multiplier: sum of shifted partial-product rows, purely combinational.
module mul5bj
    import mul5b_pkg::*;
(
    input  logic [OPW-1:0] x,
    input  logic [OPW-1:0] y,
    output logic [PW-1:0]  z
);

    always_comb begin
        z = '0;
        for (int i = 0; i < int'(OPW); i++) begin
            if (y[i]) begin
                z = z + (PW'(x) << i);
            end
        end
    end

endmodule

// File: rtl/mul5b_arb.sv
// Round-robin arbiter sharing one mul5bj among NREQ requesters.
// Optional MUL5B_ARB_ZERO_SKIP_EN: zero operands bypass the MUL state.
module mul5b_arb
    import mul5b_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic       clk,
    input  logic       rst,
    mul5b_arb_if.slave bus
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [OPW-1:0]  opx_q, opx_d;
    logic [OPW-1:0]  opy_q, opy_d;
    logic [PW-1:0]   res_q, res_d;
    logic            out_valid_q, out_valid_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gidx;
    logic [NREQ-1:0] req_ready_c;
    logic [OPW-1:0]  gx_c, gy_c;
    logic [PW-1:0]   z_c;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req  (bus.req_valid),
        .ptr  (ptr_q),
        .gnt  (gnt),
        .gidx (gidx)
    );

    mul5bj u_mul (
        .x (opx_q),
        .y (opy_q),
        .z (z_c)
    );

    assign gx_c = bus.req_x[OPW*gidx +: OPW];
    assign gy_c = bus.req_y[OPW*gidx +: OPW];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        opx_d       = opx_q;
        opy_d       = opy_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_c = gnt;
                    opx_d       = gx_c;
                    opy_d       = gy_c;
                    id_d        = gidx;
                    ptr_d       = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    state_d     = MUL;
`ifdef MUL5B_ARB_ZERO_SKIP_EN
                    if (gx_c == '0 || gy_c == '0) begin
                        res_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end
            MUL: begin
                res_d       = z_c;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Completing the handshake never grants in the same cycle.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            opx_q       <= '0;
            opy_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            opx_q       <= opx_d;
            opy_q       <= opy_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_z     = res_q;
    assign bus.out_id    = id_q;

endmodule

// File: tb/tb_mul5b_arb.sv
// Directed self-checking bench for mul5b_arb with NREQ=4.
module tb_mul5b_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

`ifdef MUL5B_ARB_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 2;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mul5b_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul5b_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int x, input int y, input logic v);
        bus.req_x[5*r +: 5] = 5'(x);
        bus.req_y[5*r +: 5] = 5'(y);
        bus.req_valid[r]    = v;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            step();
            n++;
        end
        if (!bus.out_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    // One isolated transaction from IDLE, checking grant, latency and result, then consuming it.
    task automatic run_one(input string tag, input int r, input int x, input int y, input int lat);
        int cyc;
        set_req(r, x, y, 1'b1);
        #1;
        check({tag, "_ready"}, int'(bus.req_ready), 1 << r);
        step();
        bus.req_valid[r] = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 8) begin
            step();
            cyc++;
        end
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_z"}, int'(bus.out_z), x * y);
        check({tag, "_id"}, int'(bus.out_id), r);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int exp_gnt[5];
        int exp_z[4];
        int n;
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_x       = '0;
        bus.req_y       = '0;
        bus.out_ready   = 1'b0;
        step();
        step();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_z", int'(bus.out_z), 0);
        check("rst_out_id", int'(bus.out_id), 0);
        check("rst_req_ready", int'(bus.req_ready), 0);
        rst = 1'b0;
        step();

        // Single request, maximum operands.
        run_one("single", 2, 31, 31, 2);

        // All four requesters from reset: grant order 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_gnt = '{0, 1, 2, 3, 0};
        exp_z   = '{21, 30, 31, 120};
        set_req(0, 3, 7, 1'b1);
        set_req(1, 5, 6, 1'b1);
        set_req(2, 31, 1, 1'b1);
        set_req(3, 12, 10, 1'b1);
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.req_ready == '0 && n < 10) begin
                step();
                n++;
            end
            check("rr_gnt", int'(bus.req_ready), 1 << exp_gnt[k]);
            step();
            if (k == 4) bus.req_valid = '0;
            wait_valid("rr");
            check("rr_id", int'(bus.out_id), exp_gnt[k]);
            check("rr_z", int'(bus.out_z), exp_z[exp_gnt[k]]);
        end
        step();
        bus.out_ready = 1'b0;

        // Backpressure: result held, no grant while DONE, grant the cycle after handshake.
        set_req(1, 9, 9, 1'b1);
        step();
        bus.req_valid[1] = 1'b0;
        set_req(3, 4, 11, 1'b1);
        wait_valid("bp");
        for (int k = 0; k < 5; k++) begin
            check("bp_z", int'(bus.out_z), 81);
            check("bp_id", int'(bus.out_id), 1);
            check("bp_ready", int'(bus.req_ready), 0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_hs_ready", int'(bus.req_ready), 0);
        step();
        bus.out_ready = 1'b0;
        #1;
        check("bp_resume", int'(bus.req_ready), 8);
        step();
        bus.req_valid = '0;
        wait_valid("bp2");
        check("bp2_z", int'(bus.out_z), 44);
        check("bp2_id", int'(bus.out_id), 3);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Zero operand.
        run_one("zero", 1, 0, 17, ZLAT);

        // Exhaustive operand sweep through requester 0.
        for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 32; y++) begin
                run_one("exh", 0, x, y, (x == 0 || y == 0) ? ZLAT : 2);
            end
        end

        // Reset while in MUL: transaction dropped, pointer back to 0.
        set_req(2, 20, 20, 1'b1);
        #1;
        check("rmid_ready", int'(bus.req_ready), 4);
        step();
        bus.req_valid = '0;
        rst = 1'b1;
        #1;
        check("rmid_out_valid", int'(bus.out_valid), 0);
        check("rmid_req_ready", int'(bus.req_ready), 0);
        step();
        rst = 1'b0;
        check("rmid_hold_valid", int'(bus.out_valid), 0);
        set_req(1, 2, 3, 1'b1);
        set_req(3, 4, 5, 1'b1);
        #1;
        check("rmid_ptr0", int'(bus.req_ready), 2);
        step();
        bus.req_valid = '0;
        wait_valid("rmid");
        check("rmid_z", int'(bus.out_z), 6);
        check("rmid_id", int'(bus.out_id), 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        run_one("reissue", 2, 20, 20, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
